// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin write-side arbiter that shares one synchronous FIFO write port
//   among NUM_REQ producers. Each granted word is written with a single-cycle
//   fifo_wr_en. The arbiter then checks the FIFO's registered wr_ack/overflow
//   response and retries a rejected word up to MAX_RETRY times. Each word ends
//   with a one-cycle done or drop pulse for its requester.
//
//   Optional feature macro: FIFO_ARB_PRIORITY_EN
//     defined   : requester 0 is fixed highest priority. Requesters 1..NUM_REQ-1
//                 rotate among themselves, and serving requester 0 leaves the
//                 rotation pointer untouched.
//     undefined : pure round-robin over all NUM_REQ requesters.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_RETRY  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            drop,
  output logic                          busy,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  localparam logic [RTY_W-1:0]   RETRY_LIMIT = RTY_W'(MAX_RETRY);
  localparam logic [RTY_W-1:0]   RETRY_ONE   = RTY_W'(1);
  localparam logic [PTR_W-1:0]   PTR_RESET   = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT_0   = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_s;

  logic [NUM_REQ-1:0]    grant_r;
  logic [NUM_REQ-1:0]    grant_s;
  logic [NUM_REQ-1:0]    done_r;
  logic [NUM_REQ-1:0]    done_s;
  logic [NUM_REQ-1:0]    drop_r;
  logic [NUM_REQ-1:0]    drop_s;
  logic                  busy_r;
  logic                  busy_s;
  logic                  wr_en_r;
  logic                  wr_en_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic [DATA_WIDTH-1:0] data_s;
  logic [PTR_W-1:0]      ptr_r;
  logic [PTR_W-1:0]      ptr_s;
  logic [RTY_W-1:0]      retry_r;
  logic [RTY_W-1:0]      retry_s;
  logic [PTR_W-1:0]      owner_r;
  logic [PTR_W-1:0]      owner_s;

  logic [DATA_WIDTH-1:0] req_word_s [NUM_REQ];
  logic [PTR_W:0]        pick_s;
  logic                  win_valid_s;
  logic [PTR_W-1:0]      win_idx_s;
  logic [PTR_W-1:0]      release_ptr_s;
  logic                  reject_s;

  // Returns {found, index} of the next requester after last_ptr in rotation order.
  // Offsets are scanned from farthest to nearest, so the nearest set request
  // is the one left in result.
  function automatic logic [PTR_W:0] pick_winner(input logic [NUM_REQ-1:0] req_v,
                                                 input logic [PTR_W-1:0]   last_ptr);
    logic [PTR_W:0]   result;
    logic [PTR_W-1:0] cand;
    result = '0;
`ifdef FIFO_ARB_PRIORITY_EN
    for (int off = NUM_REQ - 1; off >= 1; off--) begin
      cand   = PTR_W'(((int'(last_ptr) - 1 + off) % (NUM_REQ - 1)) + 1);
      result = req_v[cand] ? {1'b1, cand} : result;
    end
    result = req_v[0] ? {1'b1, {PTR_W{1'b0}}} : result;
`else
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand   = PTR_W'((int'(last_ptr) + off) % NUM_REQ);
      result = req_v[cand] ? {1'b1, cand} : result;
    end
`endif
    return result;
  endfunction

  assign pick_s      = pick_winner(req, ptr_r);
  assign win_valid_s = pick_s[PTR_W];
  assign win_idx_s   = pick_s[PTR_W-1:0];
  // An explicit overflow and a missing response are both treated as a reject.
  assign reject_s    = fifo_overflow | ~fifo_wr_ack;

  // Split the flat request data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_word_s[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Rotation pointer to commit when the current owner's word is finished.
  always_comb begin
`ifdef FIFO_ARB_PRIORITY_EN
    if (owner_r == '0) begin
      release_ptr_s = ptr_r;
    end else begin
      release_ptr_s = owner_r;
    end
`else
    release_ptr_s = owner_r;
`endif
  end

  // Next-state selection for the arbitration FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (win_valid_s && !fifo_full) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_RESP;
      ST_RESP: begin
        if (fifo_wr_ack) begin
          state_s = ST_IDLE;
        end else if (reject_s && (retry_r < RETRY_LIMIT)) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!fifo_full) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the per-transaction bookkeeping.
  always_comb begin
    grant_s = grant_r;
    done_s  = '0;
    drop_s  = '0;
    wr_en_s = 1'b0;
    busy_s  = (state_s != ST_IDLE);
    data_s  = data_r;
    ptr_s   = ptr_r;
    retry_s = retry_r;
    owner_s = owner_r;
    case (state_r)
      ST_IDLE: begin
        if (win_valid_s && !fifo_full) begin
          grant_s = ONE_HOT_0 << win_idx_s;
          owner_s = win_idx_s;
          data_s  = req_word_s[win_idx_s];
          wr_en_s = 1'b1;
          retry_s = '0;
        end else begin
          grant_s = '0;
        end
      end
      ST_ISSUE: wr_en_s = 1'b0;
      ST_RESP: begin
        if (fifo_wr_ack) begin
          done_s  = grant_r;
          grant_s = '0;
          ptr_s   = release_ptr_s;
          retry_s = '0;
        end else if (reject_s && (retry_r < RETRY_LIMIT)) begin
          retry_s = retry_r + RETRY_ONE;
        end else begin
          drop_s  = grant_r;
          grant_s = '0;
          ptr_s   = release_ptr_s;
          retry_s = '0;
        end
      end
      ST_WAIT: begin
        if (!fifo_full) begin
          wr_en_s = 1'b1;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      default: grant_s = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered outputs, rotation pointer, retry count and latched word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_r <= '0;
      done_r  <= '0;
      drop_r  <= '0;
      busy_r  <= 1'b0;
      wr_en_r <= 1'b0;
      data_r  <= '0;
      ptr_r   <= PTR_RESET;
      retry_r <= '0;
      owner_r <= '0;
    end else begin
      grant_r <= grant_s;
      done_r  <= done_s;
      drop_r  <= drop_s;
      busy_r  <= busy_s;
      wr_en_r <= wr_en_s;
      data_r  <= data_s;
      ptr_r   <= ptr_s;
      retry_r <= retry_s;
      owner_r <= owner_s;
    end
  end

  assign grant        = grant_r;
  assign done         = done_r;
  assign drop         = drop_r;
  assign busy         = busy_r;
  assign fifo_wr_en   = wr_en_r;
  assign fifo_data_in = data_r;

endmodule
